button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumes the clean level from the debouncer and turns it into one-cycle event pulses for the control logic.
- Events: press, release, short press, long press, and auto-repeat while held.
- Sits between the debouncer output and menu/control FSMs, one instance per button.
- The input is already synchronous to clk and bounce-free; this block does no filtering.

Parameters:
- LONG_CYCLES, 50000000: hold time, in clk cycles, from press_pulse to long_press. Must be ≥ 2.
- REPEAT_CYCLES, 10000000: period, in clk cycles, of repeat_pulse after long_press. 0 disables repeat.
- CNT_W, 32: counter width. Must satisfy 2**CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- level  input  1  debounced button level, 1 = pressed.
- held  output  1  high while in PRESSED or LONG_HELD.
- press_pulse  output  1  one-cycle pulse on the press edge.
- release_pulse  output  1  one-cycle pulse on the release edge.
- short_press  output  1  one-cycle pulse on release when long_press has not fired.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while held after long_press.

Behaviour:
- Reset:
  - state = IDLE, cnt = 0.
  - All outputs are 0, asynchronously.
  - The first active edge after deassertion samples level normally. A level already high at that edge counts as a press.
- All outputs are registered. Each event is visible in the cycle after the clock edge that decides it.
- States: IDLE, PRESSED, LONG_HELD. Transitions are evaluated on each rising edge from sampled level:
- IDLE:
  - level=1: go to PRESSED, cnt<=0, press_pulse<=1, held<=1.
  - Otherwise stay.
- PRESSED, level=0:
  - Go to IDLE, release_pulse<=1, short_press<=1, held<=0.
  - This takes priority over the long threshold on the same edge.
- PRESSED, level=1:
  - If cnt==LONG_CYCLES-1: go to LONG_HELD, cnt<=0, long_press<=1.
  - Otherwise cnt<=cnt+1.
- LONG_HELD, level=0:
  - Go to IDLE, release_pulse<=1, held<=0.
  - No short_press.
  - Release has priority over a coincident repeat.
- LONG_HELD, level=1:
  - If REPEAT_CYCLES≠0 and cnt==REPEAT_CYCLES-1: repeat_pulse<=1, cnt<=0.
  - Otherwise cnt<=cnt+1 when REPEAT_CYCLES≠0; cnt holds when REPEAT_CYCLES=0.
- Timing: if press_pulse is high in cycle t,
  - long_press is high in cycle t+LONG_CYCLES;
  - the k-th repeat_pulse (k≥1) is high in cycle t+LONG_CYCLES+k·REPEAT_CYCLES.
- Release timing: level sampled 0 at edge E gives release_pulse (and short_press, if from PRESSED) in the cycle after E.
- Pulses are strictly one cycle wide; no pulse may be high in two consecutive cycles.
- Exclusivity: press_pulse and release_pulse are never high together. short_press only accompanies release_pulse.
- Minimum press: a one-cycle-wide level high produces press_pulse, then release_pulse+short_press in the next cycle. held is high for exactly that one cycle.
- A new press in the cycle after a release is accepted normally.
- cnt never wraps; it is compared with equality and reset at each threshold.
- Reset asserted mid-hold aborts silently: no release_pulse or short_press is emitted.

Decomposition:
- Shared package:
  - state enum (IDLE, PRESSED, LONG_HELD);
  - default timing constants (LONG_CYCLES, REPEAT_CYCLES for the 50 MHz board clock), shared with the debounce instantiations.
- No sub-module: the FSM plus one counter is a single always block with a registered output stage.

Test Plan (LONG_CYCLES=10, REPEAT_CYCLES=4):
- Reset with level=1 held → all outputs 0 during reset. press_pulse in the cycle after the first edge post-deassert.
- level high for 5 cycles, then low → press_pulse once, held high 5 cycles. Then release_pulse and short_press together in one cycle; long_press never fires.
- level high for 30 cycles, press_pulse at t:
  - long_press at t+10;
  - repeat_pulse at t+14, t+18, t+22, t+26;
  - on release, release_pulse with no short_press.
- Release coincident with the threshold: level falls so that the edge with cnt==9 samples 0 → release_pulse+short_press, no long_press. Repeat this check against the repeat threshold.
- level toggles 1,0,1,0 on consecutive cycles → alternating single-cycle press_pulse and release_pulse+short_press; never two pulses high at once.
- Async reset asserted mid-LONG_HELD, between clock edges → outputs 0 immediately, state IDLE. Re-press after deassert restarts timing from 0. Parallel check with REPEAT_CYCLES=0 → no repeat_pulse ever.

Source files
------------

// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared state encoding, event record and board timing defaults
package button_event_pkg;

  // Defaults for the 50 MHz board clock; the debounce instances use the same values.
  localparam int CLK_HZ                = 50_000_000;
  localparam int LONG_CYCLES_DEFAULT   = CLK_HZ;
  localparam int REPEAT_CYCLES_DEFAULT = CLK_HZ / 5;
  localparam int CNT_W_DEFAULT         = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;

  typedef struct packed {
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
  } event_t;

  localparam event_t EVENT_NONE = '0;

endpackage

// File: rtl/button_event_if.sv
// rtl/button_event_if.sv - debounced level in, one-cycle button events out
interface button_event_if;
  import button_event_pkg::*;

  logic level;
  logic held;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic repeat_pulse;

  // master: debouncer / control side; slave: the event generator itself
  modport master (
    output level,
    input  held,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press,
    input  repeat_pulse
  );

  modport slave (
    input  level,
    output held,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output repeat_pulse
  );

endinterface

// File: rtl/button_event.sv
// rtl/button_event.sv - press/release/short/long/repeat event generator for one button
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  button_event_if.slave bus
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  event_t           ev_q, ev_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ev_q  <= EVENT_NONE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ev_q  <= ev_n;
    end
  end

  // Release is tested before either threshold so it wins on a coincident edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ev_n    = EVENT_NONE;
    case (state)
      ST_IDLE: begin
        if (bus.level) begin
          state_n          = ST_PRESSED;
          cnt_n            = '0;
          ev_n.press_pulse = 1'b1;
          ev_n.held        = 1'b1;
        end
      end
      ST_PRESSED: begin
        ev_n.held = 1'b1;
        if (!bus.level) begin
          state_n            = ST_IDLE;
          ev_n.held          = 1'b0;
          ev_n.release_pulse = 1'b1;
          ev_n.short_press   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n         = ST_LONG_HELD;
          cnt_n           = '0;
          ev_n.long_press = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_LONG_HELD: begin
        ev_n.held = 1'b1;
        if (!bus.level) begin
          state_n            = ST_IDLE;
          ev_n.held          = 1'b0;
          ev_n.release_pulse = 1'b1;
        end else if (REPEAT_EN) begin
          if (cnt == REPEAT_LAST) begin
            cnt_n             = '0;
            ev_n.repeat_pulse = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.held          = ev_q.held;
  assign bus.press_pulse   = ev_q.press_pulse;
  assign bus.release_pulse = ev_q.release_pulse;
  assign bus.short_press   = ev_q.short_press;
  assign bus.long_press    = ev_q.long_press;
  assign bus.repeat_pulse  = ev_q.repeat_pulse;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - directed vector bench for button_event (LONG=10, REPEAT=4 and REPEAT=0)
module tb_button_event;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  button_event_if bus_a ();
  button_event_if bus_b ();

  button_event #(.LONG_CYCLES(10), .REPEAT_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  button_event #(.LONG_CYCLES(10), .REPEAT_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  // bit order: held, press, release, short, long, repeat
  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_HELD  = 6'b100000;
  localparam logic [5:0] E_PRESS = 6'b110000;
  localparam logic [5:0] E_SHORT = 6'b001100;
  localparam logic [5:0] E_REL   = 6'b001000;
  localparam logic [5:0] E_LONG  = 6'b100010;
  localparam logic [5:0] E_REP   = 6'b100001;

  typedef struct {
    logic       level;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] obs_a();
    return {bus_a.held, bus_a.press_pulse, bus_a.release_pulse,
            bus_a.short_press, bus_a.long_press, bus_a.repeat_pulse};
  endfunction

  function automatic logic [5:0] obs_b();
    return {bus_b.held, bus_b.press_pulse, bus_b.release_pulse,
            bus_b.short_press, bus_b.long_press, bus_b.repeat_pulse};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b (held,press,rel,short,long,rep) t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Called just after a negedge: drive level, let one rising edge pass, sample 1 ns later.
  task automatic step(input string name, input logic lvl,
                      input logic [5:0] exp_a, input logic [5:0] exp_b);
    bus_a.level = lvl;
    bus_b.level = lvl;
    @(posedge clk);
    #1;
    chk({name, "/rep4"}, obs_a(), exp_a);
    chk({name, "/rep0"}, obs_b(), exp_b);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] ea, eb;

    // Reset held with level already high: everything stays quiet.
    bus_a.level = 1'b1;
    bus_b.level = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_quiet/rep4", obs_a(), E_NONE);
    chk("reset_quiet/rep0", obs_b(), E_NONE);
    @(negedge clk);
    reset = 1'b0;
    step("first_edge_press", 1'b1, E_PRESS, E_PRESS);
    step("first_edge_rel", 1'b0, E_SHORT, E_SHORT);
    step("idle", 1'b0, E_NONE, E_NONE);

    // Five-cycle press followed by back-to-back single-cycle toggles.
    vecs.push_back('{1'b1, E_PRESS});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, E_HELD});
    vecs.push_back('{1'b0, E_SHORT});
    vecs.push_back('{1'b0, E_NONE});
    vecs.push_back('{1'b1, E_PRESS});
    vecs.push_back('{1'b0, E_SHORT});
    vecs.push_back('{1'b1, E_PRESS});
    vecs.push_back('{1'b0, E_SHORT});
    vecs.push_back('{1'b0, E_NONE});
    foreach (vecs[i]) begin
      step($sformatf("table[%0d]", i), vecs[i].level, vecs[i].exp, vecs[i].exp);
    end

    // 30-cycle hold: long at t+10, repeats at t+14,18,22,26, plain release.
    for (int i = 0; i < 30; i++) begin
      ea = E_HELD;
      eb = E_HELD;
      if (i == 0) begin ea = E_PRESS; eb = E_PRESS; end
      if (i == 10) begin ea = E_LONG; eb = E_LONG; end
      if (i == 14 || i == 18 || i == 22 || i == 26) ea = E_REP;
      step($sformatf("hold30[%0d]", i), 1'b1, ea, eb);
    end
    step("hold30_release", 1'b0, E_REL, E_REL);
    step("idle", 1'b0, E_NONE, E_NONE);

    // Release sampled on the long-threshold edge: short press, no long.
    for (int i = 0; i < 10; i++)
      step($sformatf("thr_long[%0d]", i), 1'b1, (i == 0) ? E_PRESS : E_HELD,
           (i == 0) ? E_PRESS : E_HELD);
    step("thr_long_release", 1'b0, E_SHORT, E_SHORT);
    step("idle", 1'b0, E_NONE, E_NONE);

    // Release sampled on the first repeat-threshold edge: release only.
    for (int i = 0; i < 14; i++) begin
      ea = (i == 0) ? E_PRESS : (i == 10) ? E_LONG : E_HELD;
      step($sformatf("thr_rep[%0d]", i), 1'b1, ea, ea);
    end
    step("thr_rep_release", 1'b0, E_REL, E_REL);
    step("idle", 1'b0, E_NONE, E_NONE);

    // Async reset in LONG_HELD between edges, then a fresh press retimes from zero.
    for (int i = 0; i < 12; i++) begin
      ea = (i == 0) ? E_PRESS : (i == 10) ? E_LONG : E_HELD;
      step($sformatf("pre_abort[%0d]", i), 1'b1, ea, ea);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset/rep4", obs_a(), E_NONE);
    chk("async_reset/rep0", obs_b(), E_NONE);
    step("abort_silent", 1'b0, E_NONE, E_NONE);
    bus_a.level = 1'b1;
    bus_b.level = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ea = (i == 0) ? E_PRESS : (i == 10) ? E_LONG : (i == 14) ? E_REP : E_HELD;
      eb = (i == 0) ? E_PRESS : (i == 10) ? E_LONG : E_HELD;
      step($sformatf("repress[%0d]", i), 1'b1, ea, eb);
    end
    step("repress_release", 1'b0, E_REL, E_REL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
